// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   - Default widths for the PC/word address and the instruction.
//   - FSM state encoding for the fetch controller.
//   - NOP word that is written into IF/ID when a redirect flushes it.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 32;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
// Control priority: i_flush > i_load > i_clr_valid > hold.
// Ports:
//   clk, rst      clock / synchronous active-high reset (clears everything)
//   i_flush       replace the contents with a NOP bubble (valid=0, pc1=held)
//   i_load        capture i_instr / i_pc1 and mark valid
//   i_clr_valid   drop valid only; instruction and pc1 are held
//   i_instr       instruction to capture
//   i_pc1         PC+1 of the instruction being captured
//   o_instr, o_pc1, o_valid  registered contents
import fetch_pkg::*;

module if_id_reg #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_load,
  input  logic               i_clr_valid,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc1,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc1,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc1;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr <= '0;
      r_pc1   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= INSTR_W'(NOP);
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc1   <= i_pc1;
      r_valid <= 1'b1;
    end else if (i_clr_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_instr = r_instr;
  assign o_pc1   = r_pc1;
  assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of a combinational instruction ROM.
// Holds the PC, drives the ROM word address and captures the ROM data into
// the IF/ID register. Handles stall, branch/jump redirect (with flush) and halt.
//
// Optional build macro FETCH_PERF_EN adds saturating 16-bit counters
// perf_fetch_cnt (fetch cycles) and perf_stall_cnt (stall cycles).
//
// Handshake/control semantics: there is no valid/ready pair here; every
// control input is a level sampled on the rising edge while in RUN, with
// priority branch_taken > jump > stall > halt_req > normal fetch.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_addr                      ROM word address (= PC register)
//   imem_rd                        ROM read data, same-cycle combinational
//   stall                          hold PC and IF/ID
//   branch_taken / branch_target   EX-stage redirect (highest priority)
//   jump / jump_target             ID-stage redirect
//   halt_req                       stop fetching, enter HALTED (rst exits)
//   if_id_instr/pc1/valid          IF/ID register contents
//   halted                         FSM is in HALTED
//   perf_fetch_cnt/perf_stall_cnt  (FETCH_PERF_EN only) performance counters
//   o_dbg_state                    current FSM state for observation
import fetch_pkg::*;

module instr_fetch #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc1,
  output logic               if_id_valid,
  output logic               halted,
`ifdef FETCH_PERF_EN
  output logic [15:0]        perf_fetch_cnt,
  output logic [15:0]        perf_stall_cnt,
`endif
  output logic [1:0]         o_dbg_state
);

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic               w_flush;
  logic               w_load;
  logic               w_clr_valid;
  logic               w_fetch;
  logic               w_stall;

  // Modulo 2^ADDR_W: the carry out is simply dropped.
  assign w_pc_inc = r_pc + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_flush      = 1'b0;
    w_load       = 1'b0;
    w_clr_valid  = 1'b0;
    w_fetch      = 1'b0;
    w_stall      = 1'b0;
    unique case (r_state)
      BOOT: begin
        // One idle cycle after reset; inputs are ignored.
        w_state_next = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          // Branch resolves in EX, so it is older than a jump in ID.
          w_pc_next = branch_target;
          w_flush   = 1'b1;
        end else if (jump) begin
          w_pc_next = jump_target;
          w_flush   = 1'b1;
        end else if (stall) begin
          w_stall = 1'b1;
        end else if (halt_req) begin
          w_state_next = HALTED;
          w_clr_valid  = 1'b1;
        end else begin
          w_pc_next = w_pc_inc;
          w_load    = 1'b1;
          w_fetch   = 1'b1;
        end
      end
      HALTED: begin
        // Frozen until reset.
      end
      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .i_flush    (w_flush),
    .i_load     (w_load),
    .i_clr_valid(w_clr_valid),
    .i_instr    (imem_rd),
    .i_pc1      (w_pc_inc),
    .o_instr    (if_id_instr),
    .o_pc1      (if_id_pc1),
    .o_valid    (if_id_valid)
  );

`ifdef FETCH_PERF_EN
  logic [15:0] r_fetch_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch && (r_fetch_cnt != 16'hFFFF)) r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`else
  // Fetch/stall strobes only feed the optional counters.
  logic w_unused_perf;
  assign w_unused_perf = w_fetch ^ w_stall;
`endif

  assign imem_addr   = r_pc;
  assign halted      = (r_state == HALTED);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a small model ROM.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        jump;
  logic [7:0]  jump_target;
  logic        halt_req;
  logic [31:0] if_id_instr;
  logic [7:0]  if_id_pc1;
  logic        if_id_valid;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int tests_run;
  int tests_failed;

  logic [31:0] rom [0:255];
  logic [31:0] exp_q [$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rd = rom[imem_addr];

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .imem_addr    (imem_addr),
    .imem_rd      (imem_rd),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt_req     (halt_req),
    .if_id_instr  (if_id_instr),
    .if_id_pc1    (if_id_pc1),
    .if_id_valid  (if_id_valid),
    .halted       (halted),
`ifdef FETCH_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .o_dbg_state  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'd0;
    jump          = 1'b0;
    jump_target   = 8'd0;
    halt_req      = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the next expected instruction word from the scoreboard queue.
  task automatic check_fetch(input string tag, input logic [7:0] exp_pc1);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_instr"}, if_id_instr, e);
    check({tag, "_pc1"}, {24'd0, if_id_pc1}, {24'd0, exp_pc1});
    check({tag, "_valid"}, {31'd0, if_id_valid}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0;
    rom[0] = 32'h20010003;
    rom[1] = 32'h20020009;
    rom[2] = 32'h00221020;
    rom[3] = 32'h00221822;
    rom[4] = 32'h00412024;
    rom[5] = 32'h002228A7;
    rom[6] = 32'h00223025;
    rom[7] = 32'hAC060050;

    idle_inputs();
    rst = 1'b1;
    step();
    // Reset must win even with every input active.
    branch_taken = 1'b1; branch_target = 8'd9; jump = 1'b1; jump_target = 8'd7;
    stall = 1'b1; halt_req = 1'b1;
    step();
    check("rst_addr",   {24'd0, imem_addr}, 32'd0);
    check("rst_valid",  {31'd0, if_id_valid}, 32'd0);
    check("rst_instr",  if_id_instr, 32'd0);
    check("rst_pc1",    {24'd0, if_id_pc1}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_state",  {30'd0, dbg_state}, 32'd0);

    // BOOT: inputs ignored for one cycle.
    rst = 1'b0;
    step();
    idle_inputs();
    check("boot_addr",  {24'd0, imem_addr}, 32'd0);
    check("boot_valid", {31'd0, if_id_valid}, 32'd0);
    check("boot_state", {30'd0, dbg_state}, 32'd1);

    // Straight-line fetch.
    exp_q.push_back(32'h20010003);
    step();
    check_fetch("f0", 8'd1);
    exp_q.push_back(32'h20020009);
    step();
    check_fetch("f1", 8'd2);
    check("f1_addr", {24'd0, imem_addr}, 32'd2);

    // Stall for 3 cycles at pc=2.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr",  {24'd0, imem_addr}, 32'd2);
      check("stall_instr", if_id_instr, 32'h20020009);
      check("stall_valid", {31'd0, if_id_valid}, 32'd1);
    end
    stall = 1'b0;
    exp_q.push_back(32'h00221020);
    step();
    check_fetch("resume", 8'd3);

    // Branch beats jump, stall and halt in the same cycle.
    branch_taken = 1'b1; branch_target = 8'd5;
    jump = 1'b1; jump_target = 8'd1; stall = 1'b1; halt_req = 1'b1;
    step();
    idle_inputs();
    check("br_addr",   {24'd0, imem_addr}, 32'd5);
    check("br_valid",  {31'd0, if_id_valid}, 32'd0);
    check("br_instr",  if_id_instr, 32'd0);
    check("br_halted", {31'd0, halted}, 32'd0);
    exp_q.push_back(32'h002228A7);
    step();
    check_fetch("br_fetch", 8'd6);

    // Jump beats stall.
    jump = 1'b1; jump_target = 8'd255; stall = 1'b1;
    step();
    idle_inputs();
    check("jmp_addr",  {24'd0, imem_addr}, 32'd255);
    check("jmp_valid", {31'd0, if_id_valid}, 32'd0);
    // Wrap at 255.
    exp_q.push_back(32'h0);
    step();
    check_fetch("wrap", 8'd0);
    check("wrap_addr", {24'd0, imem_addr}, 32'd0);
    exp_q.push_back(32'h20010003);
    step();
    check_fetch("after_wrap", 8'd1);

    // Redirect to current pc: one bubble then same address refetched.
    jump = 1'b1; jump_target = 8'd1;
    step();
    idle_inputs();
    check("self_addr",  {24'd0, imem_addr}, 32'd1);
    check("self_valid", {31'd0, if_id_valid}, 32'd0);
    exp_q.push_back(32'h20020009);
    step();
    check_fetch("self_fetch", 8'd2);

    // Halt, then random inputs cannot move anything.
    halt_req = 1'b1;
    step();
    check("halt_flag",  {31'd0, halted}, 32'd1);
    check("halt_valid", {31'd0, if_id_valid}, 32'd0);
    check("halt_addr",  {24'd0, imem_addr}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      stall         = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = 8'($urandom_range(0, 255));
      jump          = 1'($urandom_range(0, 1));
      jump_target   = 8'($urandom_range(0, 255));
      halt_req      = 1'($urandom_range(0, 1));
      step();
      check("halted_addr",  {24'd0, imem_addr}, 32'd2);
      check("halted_flag",  {31'd0, halted}, 32'd1);
      check("halted_valid", {31'd0, if_id_valid}, 32'd0);
    end
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rehalt_addr",  {24'd0, imem_addr}, 32'd0);
    check("rehalt_flag",  {31'd0, halted}, 32'd0);
    check("rehalt_state", {30'd0, dbg_state}, 32'd0);

`ifdef FETCH_PERF_EN
    step(); // BOOT
    for (int i = 0; i < 4; i++) step();
    stall = 1'b1;
    step();
    step();
    stall = 1'b0;
    for (int i = 0; i < 3; i++) step();
    halt_req = 1'b1;
    step();
    step();
    idle_inputs();
    check("perf_fetch", {16'd0, perf_fetch_cnt}, 32'd7);
    check("perf_stall", {16'd0, perf_stall_cnt}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_fetch_rst", {16'd0, perf_fetch_cnt}, 32'd0);
    check("perf_stall_rst", {16'd0, perf_stall_cnt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
